// File: rtl/imul.sv
// imul: unsigned N x N multiplier built from an AND-array of partial products, a carry-save tree and one final adder.
// Define IMUL_PIPE_EN to register the tree's sum/carry vectors before the final adder (latency 2 instead of 1).
module imul #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] out,
    output logic           out_valid
);

    localparam int W2 = 2 * N;

    function automatic int next_rows(input int c);
        return (c / 3) * 2 + (c % 3);
    endfunction

    function automatic int rows_at(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = next_rows(c);
        return c;
    endfunction

    function automatic int num_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        for (int i = 0; i < n; i++) begin
            if (c > 2) begin
                c = next_rows(c);
                l++;
            end
        end
        return l;
    endfunction

    function automatic logic [W2-1:0] csa_sum(input logic [W2-1:0] x, input logic [W2-1:0] y,
                                              input logic [W2-1:0] z);
        return x ^ y ^ z;
    endfunction

    // The carry bit shifted out of the top is dropped: the true product always fits in 2N bits.
    function automatic logic [W2-1:0] csa_carry(input logic [W2-1:0] x, input logic [W2-1:0] y,
                                                input logic [W2-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    localparam int NLEV = num_levels(N);

    for (genvar l = 0; l <= NLEV; l++) begin : g_lvl
        localparam int ROWS = rows_at(N, l);
        logic [W2-1:0] w_row [ROWS];

        if (l == 0) begin : g_pp
            for (genvar k = 0; k < N; k++) begin : g_k
                assign w_row[k] = W2'(a & {N{b[k]}}) << k;
            end
        end else begin : g_csa
            // Each group of three rows becomes a sum/carry pair; leftover rows pass through untouched.
            localparam int PREV = rows_at(N, l - 1);
            localparam int GRP  = PREV / 3;
            for (genvar k = 0; k < ROWS; k++) begin : g_k
                if (k < 2 * GRP) begin : g_red
                    if (k % 2 == 0) begin : g_s
                        assign w_row[k] = csa_sum(g_lvl[l-1].w_row[3*(k/2)],
                                                  g_lvl[l-1].w_row[3*(k/2)+1],
                                                  g_lvl[l-1].w_row[3*(k/2)+2]);
                    end else begin : g_c
                        assign w_row[k] = csa_carry(g_lvl[l-1].w_row[3*(k/2)],
                                                    g_lvl[l-1].w_row[3*(k/2)+1],
                                                    g_lvl[l-1].w_row[3*(k/2)+2]);
                    end
                end else begin : g_pass
                    assign w_row[k] = g_lvl[l-1].w_row[k+GRP];
                end
            end
        end
    end

    logic [W2-1:0] w_sum;
    logic [W2-1:0] w_carry;
    logic [W2-1:0] w_fin_sum;
    logic [W2-1:0] w_fin_carry;
    logic          w_fin_vld;

    assign w_sum   = g_lvl[NLEV].w_row[0];
    assign w_carry = g_lvl[NLEV].w_row[1];

`ifdef IMUL_PIPE_EN
    logic [W2-1:0] r_sum_p0;
    logic [W2-1:0] r_carry_p0;
    logic          r_vld_p0;

    // Stage p0: carry-save vectors registered ahead of the final adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= in_valid;
        end
        if (in_valid) begin
            r_sum_p0   <= w_sum;
            r_carry_p0 <= w_carry;
        end
    end

    assign w_fin_sum   = r_sum_p0;
    assign w_fin_carry = r_carry_p0;
    assign w_fin_vld   = r_vld_p0;
`else
    assign w_fin_sum   = w_sum;
    assign w_fin_carry = w_carry;
    assign w_fin_vld   = in_valid;
`endif

    logic [W2-1:0] r_out;
    logic          r_out_vld;

    // Output stage: final carry-propagate add; product held across bubble cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= w_fin_vld;
            if (w_fin_vld) begin
                r_out <= w_fin_sum + w_fin_carry;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_vld;

endmodule

// File: tb/tb_imul.sv
// Scoreboard bench for imul: expected products queued at drive time, popped when out_valid appears.
// Latency expectation follows IMUL_PIPE_EN (2 when defined, 1 otherwise).
module tb_imul;

    localparam int N = 24;
`ifdef IMUL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [2*N-1:0] prod;
        int             due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] out;
    logic           out_valid;

    int             n_chk = 0;
    int             n_fail = 0;
    int             n_vld = 0;
    int             cyc = 0;
    logic           rst_q = 1'b1;
    bit             mon_en = 1'b0;
    logic [2*N-1:0] last_out;
    exp_t           sb[$];

    imul #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out      (out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        in_valid = v;
        a = x;
        b = y;
        if (v && !rst) begin
            e.prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};
            e.due  = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic [2*N-1:0] hold;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (out_valid === 1'b1) begin
                    n_vld++;
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_valid: out_valid=1 out=%h at cycle %0d, required no output", out, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (out !== e.prod) begin
                            n_fail++;
                            $display("FAIL product: out=%h, required %h", out, e.prod);
                        end
                        n_chk++;
                        if (cyc != e.due) begin
                            n_fail++;
                            $display("FAIL latency: output at cycle %0d, required cycle %0d", cyc, e.due);
                        end
                    end
                    last_out = out;
                end else begin
                    hold = rst_q ? '0 : last_out;
                    n_chk++;
                    if (out !== hold) begin
                        n_fail++;
                        $display("FAIL hold: out=%h while idle, required %h", out, hold);
                    end
                    if (sb.size() > 0 && sb[0].due <= cyc) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL missing: out_valid=%b at cycle %0d, required product %h", out_valid, cyc, sb[0].prod);
                        void'(sb.pop_front());
                    end
                    last_out = hold;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 24'd3, 24'd5);
        repeat (3) step();
        @(negedge clk);
        n_chk++;
        if (out !== '0) begin
            n_fail++;
            $display("FAIL reset_out: out=%h, required 0", out);
        end
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: out_valid=%b, required 0", out_valid);
        end
        step();
        rst = 1'b0;
        last_out = '0;
        mon_en = 1'b1;
        drive(1'b1, 24'd7, 24'd9);
        step();
        drive(1'b0, 24'd0, 24'd0);
        repeat (LAT + 3) step();
        n_chk++;
        if (out !== 48'd63) begin
            n_fail++;
            $display("FAIL first_after_reset: out=%h, required %h", out, 48'd63);
        end
    endtask

    task automatic test_basic();
        int v0;
        v0 = n_vld;
        drive(1'b1, 24'd3, 24'd5);
        step();
        drive(1'b0, 24'd0, 24'd0);
        repeat (LAT + 3) step();
        n_chk++;
        if (n_vld - v0 != 1) begin
            n_fail++;
            $display("FAIL basic_pulses: out_valid pulses=%0d, required 1", n_vld - v0);
        end
        n_chk++;
        if (out !== 48'd15) begin
            n_fail++;
            $display("FAIL basic_value: out=%h, required %h", out, 48'd15);
        end
    endtask

    task automatic test_max();
        drive(1'b1, '1, '1);
        step();
        drive(1'b0, 24'd0, 24'd0);
        repeat (LAT + 2) step();
        n_chk++;
        if (out !== 48'hFFFFFE000001) begin
            n_fail++;
            $display("FAIL max_operands: out=%h, required %h", out, 48'hFFFFFE000001);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = n_vld;
        drive(1'b1, 24'd0, 24'hABCDEF);
        step();
        drive(1'b1, 24'h123456, 24'd1);
        step();
        drive(1'b0, 24'd0, 24'd0);
        repeat (LAT + 2) step();
        n_chk++;
        if (n_vld - v0 != 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: out_valid pulses=%0d, required 2", n_vld - v0);
        end
        n_chk++;
        if (out !== 48'h123456) begin
            n_fail++;
            $display("FAIL b2b_last: out=%h, required %h", out, 48'h123456);
        end
    endtask

    task automatic test_random_stream();
        int v0;
        logic [31:0] ra;
        logic [31:0] rb;
        v0 = n_vld;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            drive(1'b1, ra[N-1:0], rb[N-1:0]);
            step();
        end
        drive(1'b0, 24'd0, 24'd0);
        repeat (LAT + 3) step();
        n_chk++;
        if (n_vld - v0 != 20) begin
            n_fail++;
            $display("FAIL stream_pulses: out_valid pulses=%0d, required 20", n_vld - v0);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL stream_drain: %0d products outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_in_flight();
        int v0;
        v0 = n_vld;
        drive(1'b1, 24'h000ABC, 24'h000DEF);
        step();
        rst = 1'b1;
        drive(1'b1, 24'h00FFFF, 24'h00FFFF);
        step();
        rst = 1'b0;
        drive(1'b0, 24'd0, 24'd0);
        sb.delete();
        @(negedge clk);
        n_chk++;
        if (out !== '0) begin
            n_fail++;
            $display("FAIL flush_out: out=%h, required 0", out);
        end
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid: out_valid=%b, required 0", out_valid);
        end
        repeat (6) step();
        n_chk++;
        if (n_vld - v0 != ((LAT == 1) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL flush_pulses: out_valid pulses=%0d, required %0d", n_vld - v0, (LAT == 1) ? 1 : 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        last_out = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_random_stream();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
